bip_datapath: RTL and testbench

Execution datapath of the BIP accumulator processor, directly downstream of the control unit (program counter, instruction memory, instruction decoder). It consumes the decoded control word (WrPC, SelA, SelB, WrAcc, Op, WrRam, RdRam, Operand), owns the accumulator, ALU and data RAM, and returns `enable_counter` to the control unit. That output stalls the program counter for synchronous data-RAM reads and freezes it permanently on halt.

---
 rtl/bip_pkg.sv | 32 +++
 rtl/bip_data_ram.sv | 36 +++
 rtl/bip_datapath.sv | 156 +++++++++++++++
 tb/tb_bip_datapath.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bip_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bip_pkg
//  Description : Shared encodings for the BIP accumulator processor. Used by
//                the control-unit decoder and the execution datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
package bip_pkg;

    // Default widths of the datapath.
    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 11;

    // Accumulator source select.
    localparam logic [1:0] SEL_A_RAM  = 2'b00;
    localparam logic [1:0] SEL_A_IMM  = 2'b01;
    localparam logic [1:0] SEL_A_ALU  = 2'b10;
    localparam logic [1:0] SEL_A_HOLD = 2'b11;

    // ALU operation select.
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Datapath sequencing states.
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/bip_data_ram.sv
`default_nettype none
// ============================================================================
//  Module      : bip_data_ram
//  Description : Single-port data RAM, DATA_W x 2^ADDR_W, synchronous write
//                and registered (synchronous) read. Contents power up to
//                zero and are not affected by reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module bip_data_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    // Single port: a write takes the port, otherwise a requested read is
    // captured into the output register.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/bip_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : bip_datapath
//  Description : BIP execution datapath: accumulator, add/sub ALU, data RAM
//                and a RUN / RD_WAIT / HALT sequencer that stalls the program
//                counter for RAM reads and freezes it on HLT.
//                Optional build macro BIP_CYCLE_COUNT_EN adds a 32-bit
//                executed-cycle counter output (cycle_count).
//  Revision    : 1.0 - initial release
// ============================================================================
module bip_datapath
    import bip_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              WrPC,
    input  logic [1:0]        SelA,
    input  logic              SelB,
    input  logic              WrAcc,
    input  logic              Op,
    input  logic              WrRam,
    input  logic              RdRam,
    input  logic [ADDR_W-1:0] Operand,
    output logic              enable_counter,
    output logic [DATA_W-1:0] acc,
    output logic              halted
`ifdef BIP_CYCLE_COUNT_EN
    ,
    output logic [31:0]       cycle_count
`endif
);

    state_t            state;
    state_t            state_next;
    logic              acc_we;
    logic              ram_we;
    logic              ram_re;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_y;
    logic [DATA_W-1:0] acc_d;

    // Immediate is a signed field; widen it to the data word.
    assign imm_ext = DATA_W'($signed(Operand));

    bip_data_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (Operand),
        .wdata (acc),
        .rdata (ram_rdata)
    );

    // State register; reset abandons any pending load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state, PC enable and write strobes. A store that also requests a
    // read completes in one cycle: the write owns the single RAM port.
    always_comb begin
        state_next     = state;
        enable_counter = 1'b0;
        acc_we         = 1'b0;
        ram_we         = 1'b0;
        ram_re         = 1'b0;
        case (state)
            ST_RUN: begin
                if (!WrPC) begin
                    state_next = ST_HALT;
                end else if (RdRam && !WrRam) begin
                    ram_re     = 1'b1;
                    state_next = ST_RD_WAIT;
                end else begin
                    ram_we         = WrRam;
                    acc_we         = WrAcc;
                    enable_counter = 1'b1;
                end
            end
            ST_RD_WAIT: begin
                // PC was held, so the control word still describes this load.
                acc_we         = WrAcc;
                enable_counter = 1'b1;
                state_next     = ST_RUN;
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
        if (reset) begin
            enable_counter = 1'b0;
        end
    end

    // ALU: two's complement add/subtract, wraps modulo 2^DATA_W.
    always_comb begin
        alu_b = SelB ? imm_ext : ram_rdata;
        if (Op == OP_SUB) begin
            alu_y = acc - alu_b;
        end else begin
            alu_y = acc + alu_b;
        end
    end

    // Accumulator source mux; HOLD recirculates the current value.
    always_comb begin
        acc_d = acc;
        case (SelA)
            SEL_A_RAM:  acc_d = ram_rdata;
            SEL_A_IMM:  acc_d = imm_ext;
            SEL_A_ALU:  acc_d = alu_y;
            SEL_A_HOLD: acc_d = acc;
            default:    acc_d = acc;
        endcase
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (acc_we) begin
            acc <= acc_d;
        end
    end

    assign halted = (state == ST_HALT);

`ifdef BIP_CYCLE_COUNT_EN
    // Counts executed cycles: every RD_WAIT cycle and every RUN cycle except
    // the HLT cycle itself, so a halted program reports its own length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_count <= '0;
        end else if ((state == ST_RD_WAIT) || ((state == ST_RUN) && WrPC)) begin
            cycle_count <= cycle_count + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bip_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bip_datapath
//  Description : Directed self-checking bench for bip_datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bip_datapath;

    logic        clk;
    logic        reset;
    logic        WrPC;
    logic [1:0]  SelA;
    logic        SelB;
    logic        WrAcc;
    logic        Op;
    logic        WrRam;
    logic        RdRam;
    logic [10:0] Operand;
    logic        enable_counter;
    logic [15:0] acc;
    logic        halted;
`ifdef BIP_CYCLE_COUNT_EN
    logic [31:0] cycle_count;
`endif

    integer tests = 0;
    integer fails = 0;

    bip_datapath dut (
        .clk            (clk),
        .reset          (reset),
        .WrPC           (WrPC),
        .SelA           (SelA),
        .SelB           (SelB),
        .WrAcc          (WrAcc),
        .Op             (Op),
        .WrRam          (WrRam),
        .RdRam          (RdRam),
        .Operand        (Operand),
        .enable_counter (enable_counter),
        .acc            (acc),
        .halted         (halted)
`ifdef BIP_CYCLE_COUNT_EN
        ,
        .cycle_count    (cycle_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control word order: WrPC, SelA, SelB, WrAcc, Op, WrRam, RdRam, Operand
    task drive(input logic wrpc, input logic [1:0] sela, input logic selb,
               input logic wracc, input logic op, input logic wrram,
               input logic rdram, input logic [10:0] operand);
        WrPC = wrpc; SelA = sela; SelB = selb; WrAcc = wracc;
        Op = op; WrRam = wrram; RdRam = rdram; Operand = operand;
    endtask

    task nop;
        drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
    endtask

    // One-cycle instruction, no checks.
    task exec1(input logic [1:0] sela, input logic selb, input logic wracc,
               input logic op, input logic wrram, input logic [10:0] operand);
        @(negedge clk);
        drive(1'b1, sela, selb, wracc, op, wrram, 1'b0, operand);
        @(posedge clk); #1;
    endtask

    // Two-cycle memory-read instruction, no checks.
    task exec2(input logic [1:0] sela, input logic selb, input logic op,
               input logic [10:0] operand);
        @(negedge clk);
        drive(1'b1, sela, selb, 1'b1, op, 1'b0, 1'b1, operand);
        @(posedge clk);
        @(posedge clk); #1;
    endtask

    task apply_reset;
        @(negedge clk);
        reset = 1'b1;
        nop;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task test_reset;
        @(negedge clk); @(negedge clk);
        tests++; if (acc !== 16'h0000) begin fails++; $display("FAIL reset_acc: got %h expected %h", acc, 16'h0000); end
        tests++; if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b expected 0", halted); end
        tests++; if (enable_counter !== 1'b0) begin fails++; $display("FAIL reset_ec_forced: got %b expected 0", enable_counter); end
        reset = 1'b0;
        #1;
        tests++; if (enable_counter !== 1'b1) begin fails++; $display("FAIL post_reset_ec: got %b expected 1", enable_counter); end
    endtask

    task test_imm_add;
        @(negedge clk);
        drive(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd5);
        #1;
        tests++; if (enable_counter !== 1'b1) begin fails++; $display("FAIL ldi_ec: got %b expected 1", enable_counter); end
        @(posedge clk); #1;
        tests++; if (acc !== 16'h0005) begin fails++; $display("FAIL ldi_acc: got %h expected %h", acc, 16'h0005); end
        @(negedge clk);
        drive(1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd3);
        #1;
        tests++; if (enable_counter !== 1'b1) begin fails++; $display("FAIL addi_ec: got %b expected 1", enable_counter); end
        @(posedge clk); #1;
        tests++; if (acc !== 16'h0008) begin fails++; $display("FAIL addi_acc: got %h expected %h", acc, 16'h0008); end
    endtask

    task test_store_load;
        @(negedge clk);
        drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h010);
        #1;
        tests++; if (enable_counter !== 1'b1) begin fails++; $display("FAIL sto_ec: got %b expected 1", enable_counter); end
        @(posedge clk); #1;
        exec1(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
        @(negedge clk);
        drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h010);
        #1;
        tests++; if (enable_counter !== 1'b0) begin fails++; $display("FAIL ld_stall_ec: got %b expected 0", enable_counter); end
        @(posedge clk); #1;
        tests++; if (acc !== 16'h0000) begin fails++; $display("FAIL ld_first_cycle_acc: got %h expected %h", acc, 16'h0000); end
        @(negedge clk); #1;
        tests++; if (enable_counter !== 1'b1) begin fails++; $display("FAIL ld_wait_ec: got %b expected 1", enable_counter); end
        @(posedge clk); #1;
        tests++; if (acc !== 16'h0008) begin fails++; $display("FAIL ld_acc: got %h expected %h", acc, 16'h0008); end
    endtask

    task test_mem_alu;
        // acc=8, RAM[0x010]=8
        exec2(2'b10, 1'b0, 1'b0, 11'h010);
        tests++; if (acc !== 16'h0010) begin fails++; $display("FAIL add_mem_acc: got %h expected %h", acc, 16'h0010); end
        exec1(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 11'd3);
        exec2(2'b10, 1'b0, 1'b1, 11'h010);
        tests++; if (acc !== 16'hFFFB) begin fails++; $display("FAIL sub_mem_acc: got %h expected %h", acc, 16'hFFFB); end
    endtask

    task test_arith;
        exec1(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 11'd0);
        exec1(2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 11'd1);
        tests++; if (acc !== 16'hFFFF) begin fails++; $display("FAIL subi_wrap_acc: got %h expected %h", acc, 16'hFFFF); end
        exec1(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 11'h7FF);
        tests++; if (acc !== 16'hFFFE) begin fails++; $display("FAIL addi_sext_acc: got %h expected %h", acc, 16'hFFFE); end
    endtask

    task test_hold;
        exec1(2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 11'd5);
        tests++; if (acc !== 16'hFFFE) begin fails++; $display("FAIL hold_acc: got %h expected %h", acc, 16'hFFFE); end
    endtask

    task test_write_wins;
        exec1(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 11'h077);
        @(negedge clk);
        drive(1'b1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 11'h020);
        #1;
        tests++; if (enable_counter !== 1'b1) begin fails++; $display("FAIL wr_rd_no_stall_ec: got %b expected 1", enable_counter); end
        @(posedge clk);
        @(negedge clk);
        drive(1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h020);
        #1;
        tests++; if (enable_counter !== 1'b0) begin fails++; $display("FAIL wr_rd_back_in_run_ec: got %b expected 0", enable_counter); end
        @(posedge clk);
        @(posedge clk); #1;
        tests++; if (acc !== 16'h00EE) begin fails++; $display("FAIL wr_rd_stored_acc: got %h expected %h", acc, 16'h00EE); end
    endtask

    task test_reset_mid_load;
        exec1(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 11'h246);
        for (int i = 0; i < 3; i++) begin
            exec1(2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 11'h030);
            exec2(2'b10, 1'b0, 1'b0, 11'h030);
        end
        exec1(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 11'd4);
        exec1(2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 11'h030);
        tests++; if (acc !== 16'h1234) begin fails++; $display("FAIL build_1234_acc: got %h expected %h", acc, 16'h1234); end
        exec1(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 11'h055);
        @(negedge clk);
        drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h030);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        tests++; if (acc !== 16'h0000) begin fails++; $display("FAIL mid_load_reset_acc: got %h expected %h", acc, 16'h0000); end
        tests++; if (enable_counter !== 1'b0) begin fails++; $display("FAIL mid_load_reset_ec: got %b expected 0", enable_counter); end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h030);
        #1;
        tests++; if (enable_counter !== 1'b0) begin fails++; $display("FAIL restart_in_run_ec: got %b expected 0", enable_counter); end
        @(posedge clk);
        @(posedge clk); #1;
        tests++; if (acc !== 16'h1234) begin fails++; $display("FAIL ram_kept_acc: got %h expected %h", acc, 16'h1234); end
    endtask

    task test_halt;
        exec1(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 11'h042);
        @(negedge clk);
        drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
        #1;
        tests++; if (enable_counter !== 1'b0) begin fails++; $display("FAIL hlt_ec: got %b expected 0", enable_counter); end
        @(posedge clk); #1;
        tests++; if (halted !== 1'b1) begin fails++; $display("FAIL hlt_halted: got %b expected 1", halted); end
        @(negedge clk);
        drive(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 11'h050);
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (enable_counter !== 1'b0) begin fails++; $display("FAIL halt_ec_%0d: got %b expected 0", i, enable_counter); end
            @(posedge clk); #1;
            tests++; if (acc !== 16'h0042) begin fails++; $display("FAIL halt_acc_%0d: got %h expected %h", i, acc, 16'h0042); end
            tests++; if (halted !== 1'b1) begin fails++; $display("FAIL halt_sticky_%0d: got %b expected 1", i, halted); end
            @(negedge clk);
        end
        apply_reset;
        exec1(2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 11'd9);
        exec2(2'b00, 1'b0, 1'b0, 11'h050);
        tests++; if (acc !== 16'h0000) begin fails++; $display("FAIL halt_no_ram_write: got %h expected %h", acc, 16'h0000); end
    endtask

`ifdef BIP_CYCLE_COUNT_EN
    task test_cycle_count;
        @(negedge clk);
        reset = 1'b1;
        nop;
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'd5);
        @(posedge clk); #1;
        exec1(2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 11'd3);
        exec2(2'b00, 1'b0, 1'b0, 11'h010);
        @(negedge clk);
        drive(1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0);
        @(posedge clk); #1;
        tests++; if (cycle_count !== 32'd4) begin fails++; $display("FAIL cycle_count_halt: got %0d expected 4", cycle_count); end
        @(posedge clk); @(posedge clk); #1;
        tests++; if (cycle_count !== 32'd4) begin fails++; $display("FAIL cycle_count_frozen: got %0d expected 4", cycle_count); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        nop;
        test_reset;
        test_imm_add;
        test_store_load;
        test_mem_alu;
        test_arith;
        test_hold;
        test_write_wins;
        test_reset_mid_load;
        test_halt;
`ifdef BIP_CYCLE_COUNT_EN
        test_cycle_count;
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
